vx_pe_deserializer: RTL and testbench

VX_PE_DESERIALIZER -- requirements
Module: VX_pe_deserializer

---
 rtl/vx_pe_deserializer.sv | 115 +++++++++++
 tb/tb_vx_pe_deserializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_pe_deserializer.sv
// Gathers NUM_PES-lane input beats into NUM_LANES-lane packets behind a registered output stage.
// A final beat can land in the same cycle the previous packet drains, so full-rate streams see no bubbles.
module vx_pe_deserializer #(
  parameter int NUM_LANES  = 4,
  parameter int NUM_PES    = 1,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            valid_in,
  input  logic [NUM_PES*DATA_WIDTH-1:0]   data_in,
  input  logic [TAG_WIDTH-1:0]            tag_in,
  output logic                            ready_in,
  output logic                            valid_out,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
  output logic [TAG_WIDTH-1:0]            tag_out,
  input  logic                            ready_out,
  output logic                            busy,
  output logic                            tag_err
);

  localparam int BATCH  = NUM_LANES / NUM_PES;
  localparam int IDX_W  = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam int LANE_W = NUM_PES * DATA_WIDTH;
  localparam int OUT_W  = NUM_LANES * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BATCH - 1);

  if (NUM_LANES % NUM_PES != 0) begin : g_bad_ratio
    $error("vx_pe_deserializer: NUM_LANES must be a multiple of NUM_PES");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag
    $error("vx_pe_deserializer: TAG_WIDTH must be at least 1");
  end

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 validOut_q, validOut_d;
  logic                 tagErr_q, tagErr_d;
  logic [TAG_WIDTH-1:0] tagCap_q;
  logic [TAG_WIDTH-1:0] finalTag;
  logic [OUT_W-1:0]     dataOut_q;
  logic [TAG_WIDTH-1:0] tagOut_q;
  logic [OUT_W-1:0]     assembled;
  logic                 outFree, isLast, accept, finalAccept;

  always_comb begin
    outFree     = !validOut_q || ready_out;
    isLast      = (idx_q == LAST);
    ready_in    = !isLast || outFree;
    accept      = valid_in && ready_in;
    finalAccept = accept && isLast;

    idx_d = idx_q;
    if (accept) begin
      idx_d = isLast ? '0 : idx_q + 1'b1;
    end

    // A new final beat keeps valid_out high even while the old packet hands off.
    validOut_d = validOut_q;
    if (finalAccept) begin
      validOut_d = 1'b1;
    end else if (ready_out) begin
      validOut_d = 1'b0;
    end

    tagErr_d = tagErr_q;
    if (accept && (idx_q != '0) && (tag_in != tagCap_q)) begin
      tagErr_d = 1'b1;
    end

    finalTag = (BATCH == 1) ? tag_in : tagCap_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_q      <= '0;
      validOut_q <= 1'b0;
      tagErr_q   <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      validOut_q <= validOut_d;
      tagErr_q   <= tagErr_d;
    end
  end

  // Only the non-final slots need storage; the final beat goes straight to the output register.
  if (BATCH > 1) begin : g_asm
    logic [OUT_W-LANE_W-1:0] asm_q;
    always_ff @(posedge clk) begin
      if (accept && !isLast) begin
        asm_q[idx_q*LANE_W +: LANE_W] <= data_in;
      end
    end
    assign assembled = {data_in, asm_q};
  end else begin : g_passthru
    assign assembled = data_in;
  end

  always_ff @(posedge clk) begin
    if (accept && (idx_q == '0)) begin
      tagCap_q <= tag_in;
    end
    if (finalAccept) begin
      dataOut_q <= assembled;
      tagOut_q  <= finalTag;
    end
  end

  assign valid_out = validOut_q;
  assign data_out  = dataOut_q;
  assign tag_out   = tagOut_q;
  assign busy      = (idx_q != '0);
  assign tag_err   = tagErr_q;

endmodule

// File: tb/tb_vx_pe_deserializer.sv
// Directed bench: a 4x1 byte-lane deserializer for the main scenarios and a 2x2 instance
// acting as a plain registered stage under a toggling ready_out.
module tb_vx_pe_deserializer;

  logic        clk = 1'b0;
  logic        resetn;
  int          checks = 0;
  int          errors = 0;

  logic        aValidIn, aReadyIn, aValidOut, aReadyOut, aBusy, aTagErr;
  logic [7:0]  aDataIn;
  logic        aTagIn, aTagOut;
  logic [31:0] aDataOut;

  logic        bValidIn, bReadyIn, bValidOut, bReadyOut, bBusy, bTagErr;
  logic [15:0] bDataIn, bDataOut;
  logic        bTagIn, bTagOut;

  always #5 clk = ~clk;

  vx_pe_deserializer #(.NUM_LANES(4), .NUM_PES(1), .DATA_WIDTH(8), .TAG_WIDTH(1)) dutA (
    .clk(clk), .resetn(resetn), .valid_in(aValidIn), .data_in(aDataIn), .tag_in(aTagIn),
    .ready_in(aReadyIn), .valid_out(aValidOut), .data_out(aDataOut), .tag_out(aTagOut),
    .ready_out(aReadyOut), .busy(aBusy), .tag_err(aTagErr));

  vx_pe_deserializer #(.NUM_LANES(2), .NUM_PES(2), .DATA_WIDTH(8), .TAG_WIDTH(1)) dutB (
    .clk(clk), .resetn(resetn), .valid_in(bValidIn), .data_in(bDataIn), .tag_in(bTagIn),
    .ready_in(bReadyIn), .valid_out(bValidOut), .data_out(bDataOut), .tag_out(bTagOut),
    .ready_out(bReadyOut), .busy(bBusy), .tag_err(bTagErr));

  // Every step advances one rising edge and settles just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic [7:0] d, input logic t);
    aValidIn = 1'b1;
    aDataIn  = d;
    aTagIn   = t;
    tick();
    aValidIn = 1'b0;
  endtask

  task automatic doReset();
    aValidIn = 1'b0;
    bValidIn = 1'b0;
    resetn   = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    aValidIn = 1'b0; aDataIn = 8'h00; aTagIn = 1'b0; aReadyOut = 1'b1;
    bValidIn = 1'b0; bDataIn = 16'h0; bTagIn = 1'b0; bReadyOut = 1'b1;
    resetn = 1'b0;
    tick();
    tick();
    checks++; if (aValidOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", aValidOut); end
    checks++; if (aBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", aBusy); end
    checks++; if (aTagErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_tag_err got %b want 0", aTagErr); end
    resetn = 1'b1;
    tick();
    checks++; if (aReadyIn !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_in got %b want 1", aReadyIn); end
    checks++; if (bReadyIn !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_ready_in got %b want 1", bReadyIn); end
  endtask

  task automatic test_single_packet();
    aReadyOut = 1'b1;
    sendBeat(8'h11, 1'b1);
    checks++; if (aBusy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b want 1", aBusy); end
    sendBeat(8'h22, 1'b1);
    sendBeat(8'h33, 1'b1);
    checks++; if (aValidOut !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid got %b want 0", aValidOut); end
    sendBeat(8'h44, 1'b1);
    checks++; if (aValidOut !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", aValidOut); end
    checks++; if (aDataOut !== 32'h44332211) begin errors++; $display("[TB] FAIL single_data got %h want 44332211", aDataOut); end
    checks++; if (aTagOut !== 1'b1) begin errors++; $display("[TB] FAIL single_tag got %b want 1", aTagOut); end
    checks++; if (aBusy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end got %b want 0", aBusy); end
    tick();
    checks++; if (aValidOut !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got %b want 0", aValidOut); end
  endtask

  task automatic test_back_to_back();
    aReadyOut = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      aValidIn = 1'b1; aDataIn = 8'(i); aTagIn = 1'b0;
      #1;
      checks++; if (aReadyIn !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_in beat %0d got %b want 1", i, aReadyIn); end
      @(posedge clk); #1;
      if (i == 4) begin
        checks++; if (aDataOut !== 32'h04030201 || aValidOut !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pkt0 got %b/%h want 1/04030201", aValidOut, aDataOut); end
      end
      if (i == 5) begin
        checks++; if (aValidOut !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap got %b want 0", aValidOut); end
      end
      if (i == 8) begin
        checks++; if (aDataOut !== 32'h08070605 || aValidOut !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pkt1 got %b/%h want 1/08070605", aValidOut, aDataOut); end
      end
    end
    aValidIn = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    aReadyOut = 1'b1;
    sendBeat(8'h10, 1'b0); sendBeat(8'h11, 1'b0); sendBeat(8'h12, 1'b0); sendBeat(8'h13, 1'b0);
    aReadyOut = 1'b0;
    sendBeat(8'h20, 1'b1); sendBeat(8'h21, 1'b1); sendBeat(8'h22, 1'b1);
    aValidIn = 1'b1; aDataIn = 8'h23; aTagIn = 1'b1;
    #1;
    checks++; if (aReadyIn !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_in got %b want 0", aReadyIn); end
    tick();
    tick();
    checks++; if (aValidOut !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid got %b want 1", aValidOut); end
    checks++; if (aDataOut !== 32'h13121110) begin errors++; $display("[TB] FAIL stall_hold got %h want 13121110", aDataOut); end
    checks++; if (aBusy !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy got %b want 1", aBusy); end
    aReadyOut = 1'b1;
    #1;
    checks++; if (aReadyIn !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready got %b want 1", aReadyIn); end
    tick();
    aValidIn = 1'b0;
    checks++; if (aValidOut !== 1'b1 || aDataOut !== 32'h23222120) begin errors++; $display("[TB] FAIL stall_swap got %b/%h want 1/23222120", aValidOut, aDataOut); end
    checks++; if (aTagOut !== 1'b1) begin errors++; $display("[TB] FAIL stall_tag got %b want 1", aTagOut); end
    tick();
    checks++; if (aValidOut !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain got %b want 0", aValidOut); end
  endtask

  task automatic test_reset_midpacket();
    aReadyOut = 1'b1;
    sendBeat(8'h55, 1'b0);
    sendBeat(8'h66, 1'b0);
    checks++; if (aBusy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_pre got %b want 1", aBusy); end
    doReset();
    checks++; if (aBusy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", aBusy); end
    sendBeat(8'hA1, 1'b0); sendBeat(8'hA2, 1'b0); sendBeat(8'hA3, 1'b0); sendBeat(8'hA4, 1'b0);
    checks++; if (aValidOut !== 1'b1 || aDataOut !== 32'hA4A3A2A1) begin errors++; $display("[TB] FAIL midrst_data got %b/%h want 1/a4a3a2a1", aValidOut, aDataOut); end
    tick();
  endtask

  task automatic test_idle_ignore();
    aReadyOut = 1'b1;
    sendBeat(8'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      aDataIn = 8'hFF; aTagIn = 1'b1;
      tick();
    end
    checks++; if (aBusy !== 1'b1 || aTagErr !== 1'b0) begin errors++; $display("[TB] FAIL idle_state got busy %b err %b want 1 0", aBusy, aTagErr); end
    sendBeat(8'h02, 1'b0); sendBeat(8'h03, 1'b0); sendBeat(8'h04, 1'b0);
    checks++; if (aDataOut !== 32'h04030201) begin errors++; $display("[TB] FAIL idle_data got %h want 04030201", aDataOut); end
    tick();
  endtask

  task automatic test_tag_err();
    aReadyOut = 1'b1;
    doReset();
    sendBeat(8'h31, 1'b0);
    sendBeat(8'h32, 1'b0);
    checks++; if (aTagErr !== 1'b0) begin errors++; $display("[TB] FAIL tagerr_early got %b want 0", aTagErr); end
    sendBeat(8'h33, 1'b1);
    checks++; if (aTagErr !== 1'b1) begin errors++; $display("[TB] FAIL tagerr_set got %b want 1", aTagErr); end
    sendBeat(8'h34, 1'b0);
    checks++; if (aTagOut !== 1'b0) begin errors++; $display("[TB] FAIL tagerr_tag_out got %b want 0", aTagOut); end
    tick();
    tick();
    checks++; if (aTagErr !== 1'b1) begin errors++; $display("[TB] FAIL tagerr_sticky got %b want 1", aTagErr); end
    doReset();
    checks++; if (aTagErr !== 1'b0) begin errors++; $display("[TB] FAIL tagerr_clear got %b want 0", aTagErr); end
  endtask

  task automatic test_single_stage();
    logic [15:0] beats [4];
    logic [16:0] expQ [$];
    logic [16:0] front;
    int sent, rcvd;
    logic outAcc, inAcc;
    beats[0] = 16'hBBAA; beats[1] = 16'hDDCC; beats[2] = 16'hFFEE; beats[3] = 16'h1122;
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 40 && !(sent == 4 && rcvd == 4); cyc++) begin
      bReadyOut = cyc[0];
      bValidIn  = (sent < 4);
      bDataIn   = beats[sent % 4];
      bTagIn    = sent[0];
      #1;
      if (cyc < 6) begin
        checks++; if (bReadyIn !== (!bValidOut || bReadyOut) || bBusy !== 1'b0) begin errors++; $display("[TB] FAIL stage_ready cyc %0d got rdy %b busy %b", cyc, bReadyIn, bBusy); end
      end
      outAcc = bValidOut && bReadyOut;
      inAcc  = bValidIn && bReadyIn;
      if (outAcc) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL stage_dup got %h want none", bDataOut);
        end else begin
          front = expQ.pop_front();
          if ({bTagOut, bDataOut} !== front) begin errors++; $display("[TB] FAIL stage_order got %h want %h", {bTagOut, bDataOut}, front); end
        end
        rcvd++;
      end
      if (inAcc) begin
        expQ.push_back({bTagIn, bDataIn});
        sent++;
      end
      @(posedge clk); #1;
    end
    bValidIn = 1'b0;
    checks++; if (rcvd !== 4 || sent !== 4) begin errors++; $display("[TB] FAIL stage_count got sent %0d rcvd %0d want 4 4", sent, rcvd); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_stall();
    test_reset_midpacket();
    test_idle_ignore();
    test_tag_err();
    test_single_stage();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
